i2c_reg_ctrl: RTL
=================

Name: i2c_reg_ctrl

Overview:
- Transaction sequencer that sits behind the byte-level I2C peripheral engine.
- Decodes the address byte, register-pointer byte and data bytes from the engine, then decides ACK/NACK.
- Owns a small 8-bit register bank with an auto-incrementing pointer and supplies read bytes on request.
- Register contents are exported so the top level can drive pins from them.

Parameters:
- DEV_ADDR, 7'h2A, 7-bit peripheral address this block answers to.
- NUM_REGS, 16, register count; must be a power of two, 2..256.
- RESET_VAL, 8'h00, value loaded into every register on reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_det  in  1  one-cycle pulse from engine: START or repeated START seen.
- stop_det  in  1  one-cycle pulse from engine: STOP seen.
- rx_valid  in  1  one-cycle pulse: rx_byte holds a complete received byte.
- rx_byte  in  8  received byte, MSB first as shifted.
- ack_valid  out  1  one-cycle pulse answering each rx_valid.
- ack  out  1  1=ACK, 0=NACK; valid when ack_valid=1.
- tx_req  in  1  one-cycle pulse: engine needs the next read byte.
- tx_nack  in  1  one-cycle pulse: controller NACKed the last read byte.
- tx_valid  out  1  one-cycle pulse answering each tx_req.
- tx_byte  out  8  read byte; valid when tx_valid=1, held until the next tx_valid.
- busy  out  1  1 whenever state is not IDLE.
- wr_strobe  out  1  one-cycle pulse on every register write.
- wr_addr  out  $clog2(NUM_REGS)  index of the register just written.
- regs_flat  out  NUM_REGS*8  register bank; reg i is at bits [8i+7:8i].

Behaviour:
- Reset (async assert, sync deassert by the upstream synchroniser):
  - state=IDLE, ptr=0, all regs=RESET_VAL.
  - ack_valid=0, ack=0, tx_valid=0, tx_byte=0, busy=0, wr_strobe=0, wr_addr=0.
- Latency: ack_valid/ack are registered and assert exactly 1 cycle after rx_valid. tx_valid/tx_byte assert exactly 1 cycle after tx_req.
- Every rx_valid receives exactly one ack_valid, including in IDLE and IGNORE.
- States:
  - IDLE: rx_valid -> NACK, stay.
  - ADDR: rx_valid with rx_byte[7:1]==DEV_ADDR -> ACK, then rx_byte[0]=0 -> PTR, rx_byte[0]=1 -> RD. Address mismatch -> NACK, -> IGNORE.
  - PTR: rx_valid -> ptr <= rx_byte mod NUM_REGS (upper bits dropped), ACK, -> WR.
  - WR: rx_valid -> reg[ptr] <= rx_byte, wr_strobe=1, wr_addr=ptr, ptr <= ptr+1 (wraps NUM_REGS-1 -> 0), ACK, stay.
  - RD: tx_req -> tx_byte <= reg[ptr], ptr <= ptr+1 (wrapping), stay. tx_nack -> IGNORE. rx_valid here is a protocol error -> NACK.
  - IGNORE: rx_valid -> NACK. tx_req -> tx_valid with tx_byte=8'hFF.
  - tx_req outside RD/IGNORE -> tx_valid with tx_byte=8'hFF.
- Global transitions (override the per-state rules):
  - start_det from any state -> ADDR, ptr retained (supports write-pointer / repeated-START / read).
  - stop_det from any state -> IDLE, ptr retained.
- Priority when events coincide:
  - start_det and stop_det together: start_det wins.
  - start_det or stop_det together with rx_valid or tx_req: the byte event is dropped; no ack_valid/tx_valid is generated and no register write occurs.
  - tx_req and tx_nack together: serve tx_req first, then -> IGNORE.
- Reset mid-transaction: immediate return to reset values; a partially written burst keeps the bytes written before reset only if no reset occurred — i.e. all regs return to RESET_VAL.

Decomposition:
- Shared package i2c_pkg:
  - state enum {IDLE, ADDR, PTR, WR, RD, IGNORE}.
  - I2C_ACK=1'b1, I2C_NACK=1'b0.
  - IDLE_TX_BYTE=8'hFF.
  - default DEV_ADDR constant.
- One sub-module, i2c_reg_file: NUM_REGS x 8 storage with one synchronous write port, one combinational read port, flat output, async reset to RESET_VAL.
- FSM, pointer and handshake logic stay in i2c_reg_ctrl.

Test Plan:
1. Reset check: after reset release, all outputs 0 and regs_flat all 8'h00. Then start_det, rx 8'h54 (0x2A, write), rx 8'h03, rx 8'hA5, rx 8'h5A, stop_det -> four ACKs; reg3=A5, reg4=5A; wr_strobe with wr_addr 3 then 4; busy=0 after stop.
2. Pointer-set then read: start, rx 8'h54, rx 8'h03, repeated start, rx 8'h55, two tx_req -> tx_byte A5 then 5A; tx_nack -> IGNORE; further tx_req -> 8'hFF.
3. Pointer wrap: write pointer 8'h0F, data 11, 22 -> reg15=11, reg0=22. Pointer byte 8'hF3 -> ptr=3.
4. Wrong address: start, rx 8'h20 -> NACK, then rx 8'h77 -> NACK; no wr_strobe; regs unchanged.
5. Coincident events: start_det and rx_valid in the same cycle -> no ack_valid that cycle, state ADDR. tx_req in IDLE -> tx_valid with 8'hFF.
6. Reset mid-write burst: assert rst_n=0 between data bytes -> outputs 0 immediately, regs return to RESET_VAL, state IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the I2C register-controller slice.
//   state_t       : transaction sequencer states
//   I2C_ACK/NACK  : acknowledge encoding towards the byte engine
//   IDLE_TX_BYTE  : filler byte returned when no register read is active
//   DEFAULT_DEV_ADDR : default 7-bit peripheral address
// ---------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    PTR,
    WR,
    RD,
    IGNORE
  } state_t;

  localparam logic I2C_ACK  = 1'b1;
  localparam logic I2C_NACK = 1'b0;

  localparam logic [7:0] IDLE_TX_BYTE     = 8'hFF;
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h2A;

endpackage

// File: rtl/i2c_reg_file.sv
// ---------------------------------------------------------------------------
// i2c_reg_file
// NUM_REGS x 8-bit register bank: one synchronous write port, one
// combinational read port and the whole bank exported as a flat vector.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_we           : write enable (one cycle)
//   i_waddr/i_wdata: write index / data
//   i_raddr        : read index
//   o_rdata        : combinational read data
//   o_regs_flat    : reg i at bits [8i+7:8i]
// ---------------------------------------------------------------------------
module i2c_reg_file #(
  parameter int          NUM_REGS  = 16,
  parameter logic [7:0]  RESET_VAL = 8'h00,
  localparam int         AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [7:0]            i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [7:0]            o_rdata,
  output logic [NUM_REGS*8-1:0] o_regs_flat
);

  logic [7:0] r_mem [NUM_REGS];

  // NOTE: the bank drives pins directly, so every entry must reset to a
  // known value; this forces flops rather than a RAM macro, which is fine
  // at this size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= RESET_VAL;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_regs_flat[8*g +: 8] = r_mem[g];
  end

endmodule

// File: rtl/i2c_reg_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_reg_ctrl
// Transaction sequencer behind a byte-level I2C peripheral engine. Decodes
// the address byte, register-pointer byte and data bytes, answers every
// received byte with ACK/NACK, and serves read bytes from a register bank
// with an auto-incrementing pointer.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start_det, stop_det  : START/repeated-START and STOP pulses
//   rx_valid, rx_byte    : received byte pulse and data
//   ack_valid, ack       : registered answer to each rx_valid (1 = ACK)
//   tx_req, tx_nack      : read-byte request, controller NACK of last byte
//   tx_valid, tx_byte    : registered answer to each tx_req (byte held)
//   busy                 : state is not IDLE
//   wr_strobe, wr_addr   : pulse and index for each register write
//   regs_flat            : register bank, reg i at bits [8i+7:8i]
// ---------------------------------------------------------------------------
module i2c_reg_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEFAULT_DEV_ADDR,
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] RESET_VAL = 8'h00,
  localparam int        AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_det,
  input  logic                  stop_det,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic                  ack_valid,
  output logic                  ack,
  input  logic                  tx_req,
  input  logic                  tx_nack,
  output logic                  tx_valid,
  output logic [7:0]            tx_byte,
  output logic                  busy,
  output logic                  wr_strobe,
  output logic [AW-1:0]         wr_addr,
  output logic [NUM_REGS*8-1:0] regs_flat
);

  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic          r_ack_valid;
  logic          r_ack;
  logic          r_tx_valid;
  logic [7:0]    r_tx_byte;
  logic          r_wr_strobe;
  logic [AW-1:0] r_wr_addr;

  logic          w_bus_evt;
  logic          w_rx;
  logic          w_tx;
  logic          w_we;
  logic [7:0]    w_rdata;

  // A START/STOP in the same cycle swallows any byte event: it belongs to
  // the transaction being torn down.
  assign w_bus_evt = start_det | stop_det;
  assign w_rx      = rx_valid & ~w_bus_evt;
  assign w_tx      = tx_req & ~w_bus_evt;
  assign w_we      = w_rx & (r_state == WR);

  i2c_reg_file #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_reg_file (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_we        (w_we),
    .i_waddr     (r_ptr),
    .i_wdata     (rx_byte),
    .i_raddr     (r_ptr),
    .o_rdata     (w_rdata),
    .o_regs_flat (regs_flat)
  );

  // NOTE: all state below is updated with non-blocking assignments so that
  // every branch sees the pre-edge values of r_state/r_ptr, regardless of
  // statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_ack_valid <= 1'b0;
      r_ack       <= I2C_NACK;
      r_tx_valid  <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
    end else begin
      // Pulses default low; ack defaults to NACK so it reads 0 when idle.
      r_ack_valid <= w_rx;
      r_ack       <= I2C_NACK;
      r_tx_valid  <= w_tx;
      r_wr_strobe <= w_we;

      if (w_tx) begin
        r_tx_byte <= (r_state == RD) ? w_rdata : IDLE_TX_BYTE;
      end

      if (w_we) begin
        r_wr_addr <= r_ptr;
      end

      if (start_det) begin
        r_state <= ADDR;
      end else if (stop_det) begin
        r_state <= IDLE;
      end else begin
        unique case (r_state)
          ADDR: begin
            if (w_rx) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                r_ack   <= I2C_ACK;
                r_state <= rx_byte[0] ? RD : PTR;
              end else begin
                r_state <= IGNORE;
              end
            end
          end
          PTR: begin
            if (w_rx) begin
              // Pointer bits beyond the bank size are dropped.
              r_ptr   <= rx_byte[AW-1:0];
              r_ack   <= I2C_ACK;
              r_state <= WR;
            end
          end
          WR: begin
            if (w_rx) begin
              r_ptr <= r_ptr + AW'(1);
              r_ack <= I2C_ACK;
            end
          end
          RD: begin
            // rx_valid here is a protocol error and is simply NACKed.
            if (w_tx) begin
              r_ptr <= r_ptr + AW'(1);
            end
            // The read byte in the same cycle is still served above.
            if (tx_nack) begin
              r_state <= IGNORE;
            end
          end
          default: ; // IDLE, IGNORE: NACK everything, serve filler bytes
        endcase
      end
    end
  end

  assign ack_valid = r_ack_valid;
  assign ack       = r_ack;
  assign tx_valid  = r_tx_valid;
  assign tx_byte   = r_tx_byte;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign busy      = (r_state != IDLE);

endmodule
